// File: rtl/mult_share_sched_if.sv
// rtl/mult_share_sched_if.sv - requester/result handshake bundle for mult_share_sched
//
// Signals:
//   req_valid   NREQ      per-requester operand valid
//   req_ready   NREQ      per-requester accept (one-hot or zero)
//   req_a       NREQ*M    requester i operand a at [i*M +: M]
//   req_x       NREQ*N    requester i operand x at [i*N +: N]
//   res_valid   1         result available
//   res_ready   1         consumer takes result
//   res_product M+N       full-width unsigned product
//   res_id      IDW       owner of res_product
// Modports: master = requesters/consumer side, slave = scheduler side.

interface mult_share_sched_if #(
    parameter int M    = 16,
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*M-1:0] req_a;
    logic [NREQ*N-1:0] req_x;
    logic              res_valid;
    logic              res_ready;
    logic [M+N-1:0]    res_product;
    logic [IDW-1:0]    res_id;

    modport master (
        output req_valid, req_a, req_x, res_ready,
        input  req_ready, res_valid, res_product, res_id
    );

    modport slave (
        input  req_valid, req_a, req_x, res_ready,
        output req_ready, res_valid, res_product, res_id
    );
endinterface

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin scheduler sharing one external multiplier
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          mult_share_sched_if.slave (requests in, results out)
//   busy         high whenever the scheduler is not idle
//   mul_a/mul_x  operands driven to the external combinational multiplier
//   mul_product  product returned by the external multiplier
//
// The multiplier path is given MUL_CYCLES cycles to settle; operands are held
// in the op registers (which drive mul_a/mul_x directly) for the whole window.

module mult_share_sched #(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int MUL_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_share_sched_if.slave   bus,
    output logic                busy,
    output logic [M-1:0]        mul_a,
    output logic [N-1:0]        mul_x,
    input  logic [M+N-1:0]      mul_product
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_q;
    logic [CW-1:0]  cnt;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] scan_cand;
    int             scan_idx;

    // Scan from the highest offset down so the requester closest to rr_ptr
    // is the last one written and therefore wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        scan_cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            scan_cand = IDW'(scan_idx);
            if (bus.req_valid[scan_cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_cand;
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && (state == IDLE) && gnt_found) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (gnt_found)                  state_next = BUSY;
            BUSY: if (cnt == '0)                  state_next = DONE;
            DONE: if (bus.res_valid && bus.res_ready) state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            id_q            <= '0;
            cnt             <= '0;
            mul_a           <= '0;
            mul_x           <= '0;
            bus.res_valid   <= 1'b0;
            bus.res_product <= '0;
            bus.res_id      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        mul_a  <= bus.req_a[gnt_idx*M +: M];
                        mul_x  <= bus.req_x[gnt_idx*N +: N];
                        id_q   <= gnt_idx;
                        rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        cnt    <= CW'(MUL_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.res_product <= mul_product;
                        bus.res_id      <= id_q;
                        bus.res_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_valid && bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - self-checking bench for mult_share_sched

module tb_mult_share_sched;

    localparam int M    = 16;
    localparam int N    = 16;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int MC   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_share_sched_if #(.M(M), .N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

    logic           busy;
    logic [M-1:0]   mul_a;
    logic [N-1:0]   mul_x;
    logic [M+N-1:0] mul_product;

    // External multiplier stand-in.
    assign mul_product = (M+N)'(mul_a) * (M+N)'(mul_x);

    mult_share_sched #(
        .M(M), .N(N), .NREQ(NREQ), .IDW(IDW), .MUL_CYCLES(MC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .mul_a       (mul_a),
        .mul_x       (mul_x),
        .mul_product (mul_product)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           edge_cnt = 0;
    bit           m_busy   = 0;
    int           m_rr     = 0;
    int           m_acc_edge = 0;
    int           m_id     = 0;
    logic [M-1:0] m_a      = '0;
    logic [N-1:0] m_x      = '0;
    int           grant_log[$];
    int           accept_edge_log[$];

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        int g;
        int k;
        if (!rst_n) begin
            check("m_rst_ready", bus.req_ready, 0);
            m_busy = 0;
            m_rr   = 0;
        end else if (!m_busy) begin
            g = -1;
            for (int j = 0; j < NREQ; j++) begin
                if (g < 0 && bus.req_valid[(m_rr + j) % NREQ]) g = (m_rr + j) % NREQ;
            end
            check("m_idle_busy", busy, 0);
            check("m_idle_res_valid", bus.res_valid, 0);
            check("m_grant", bus.req_ready, (g < 0) ? 0 : (1 << g));
            if (g >= 0) begin
                m_busy     = 1;
                m_a        = bus.req_a[g*M +: M];
                m_x        = bus.req_x[g*N +: N];
                m_id       = g;
                m_acc_edge = edge_cnt + 1;
                m_rr       = (g + 1) % NREQ;
                grant_log.push_back(g);
                accept_edge_log.push_back(m_acc_edge);
            end
        end else begin
            k = edge_cnt - m_acc_edge;
            check("m_busy", busy, 1);
            check("m_ready_held", bus.req_ready, 0);
            check("m_mul_a", mul_a, m_a);
            check("m_mul_x", mul_x, m_x);
            check("m_res_valid", bus.res_valid, (k >= MC) ? 1 : 0);
            if (k >= MC) begin
                check("m_product", bus.res_product, 64'(m_a) * 64'(m_x));
                check("m_id", bus.res_id, m_id);
                if (bus.res_valid && bus.res_ready) m_busy = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [M-1:0] a, input logic [N-1:0] x);
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*M +: M]    = a;
        bus.req_x[i*N +: N]    = x;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        g = '0;
        for (int c = 0; c < 40 && g == 0; c++) begin
            #1;
            g = bus.req_ready;
            if (g == 0) tick();
        end
        if (g == 0) check("grant_timeout", 0, 1);
    endtask

    task automatic wait_res();
        bit seen;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            #1;
            seen = bus.res_valid;
            if (!seen) tick();
        end
        if (!seen) check("res_timeout", 0, 1);
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 40 && !idle; c++) begin
            #1;
            idle = !busy && !bus.res_valid;
            if (!idle) tick();
        end
        if (!idle) check("drain_timeout", 0, 1);
    endtask

    task automatic run_job(input int i, input logic [M-1:0] a, input logic [N-1:0] x,
                           input logic [M+N-1:0] exp);
        logic [NREQ-1:0] g;
        set_req(i, a, x);
        wait_grant(g);
        check("t2_grant", g, 1 << i);
        tick();
        clr_req(i);
        wait_res();
        check("t2_product", bus.res_product, exp);
        check("t2_id", bus.res_id, i);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_x     = '0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_x", mul_x, 0);
        check("rst_res_product", bus.res_product, 0);
        check("rst_res_id", bus.res_id, 0);

        // 1: single requester 3, latency pinned by hand
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        set_req(3, 16'h00FF, 16'h0101);
        #1;
        check("t1_ready", bus.req_ready, 4'b1000);
        tick();
        clr_req(3);
        #1;
        check("t1_ready_off", bus.req_ready, 0);
        check("t1_valid_e0", bus.res_valid, 0);
        tick();
        check("t1_valid_e1", bus.res_valid, 0);
        tick();
        check("t1_valid_e2", bus.res_valid, 1);
        check("t1_product", bus.res_product, 32'h0000FFFF);
        check("t1_id", bus.res_id, 3);
        tick();
        check("t1_valid_after", bus.res_valid, 0);
        check("t1_busy_after", busy, 0);

        // 2: operand corner values
        run_job(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run_job(1, 16'h0000, 16'h1234, 32'h00000000);
        run_job(2, 16'h0001, 16'hABCD, 32'h0000ABCD);

        // 3: all requesters contend, round-robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        grant_log.delete();
        accept_edge_log.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 1), 16'(i + 10));
        for (int c = 0; c < 60 && grant_log.size() < 6; c++) tick();
        bus.req_valid = '0;
        drain();
        check("t3_grants", grant_log.size(), 6);
        if (grant_log.size() >= 6) begin
            check("t3_order0", grant_log[0], 0);
            check("t3_order1", grant_log[1], 1);
            check("t3_order2", grant_log[2], 2);
            check("t3_order3", grant_log[3], 3);
            check("t3_order4", grant_log[4], 0);
            check("t3_order5", grant_log[5], 1);
            for (int i = 1; i < 6; i++)
                check("t3_spacing", accept_edge_log[i] - accept_edge_log[i-1], MC + 2);
        end

        // 4: consumer stalls in DONE
        bus.res_ready = 1'b0;
        set_req(1, 16'd3, 16'd5);
        wait_grant(g);
        check("t4_grant", g, 4'b0010);
        tick();
        clr_req(1);
        wait_res();
        set_req(2, 16'd7, 16'd9);
        for (int c = 0; c < 5; c++) begin
            check("t4_hold_valid", bus.res_valid, 1);
            check("t4_hold_product", bus.res_product, 32'd15);
            check("t4_hold_id", bus.res_id, 1);
            check("t4_hold_ready", bus.req_ready, 0);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        check("t4_valid_done", bus.res_valid, 0);
        check("t4_busy_done", busy, 0);
        check("t4_next_grant", bus.req_ready, 4'b0100);
        tick();
        clr_req(2);
        drain();

        // 5: reset in the middle of a job
        set_req(1, 16'd11, 16'd13);
        wait_grant(g);
        check("t5_grant", g, 4'b0010);
        tick();
        clr_req(1);
        tick();
        rst_n = 1'b0;
        set_req(0, 16'd2, 16'd3);
        set_req(2, 16'd4, 16'd5);
        #1;
        check("t5_ready_in_rst", bus.req_ready, 0);
        tick();
        check("t5_res_valid", bus.res_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_ready_rst", bus.req_ready, 0);
        rst_n = 1'b1;
        #1;
        check("t5_first_after_rst", bus.req_ready, 4'b0001);
        tick();
        clr_req(0);
        drain();
        wait_grant(g);
        check("t5_second", g, 4'b0100);
        tick();
        clr_req(2);
        drain();

        // 6: requester 1 withdraws while 0 is serviced
        set_req(0, 16'd6, 16'd7);
        set_req(1, 16'd8, 16'd9);
        set_req(2, 16'd10, 16'd11);
        #1;
        check("t6_first", bus.req_ready, 4'b0001);
        tick();
        clr_req(0);
        tick();
        clr_req(1);
        wait_res();
        wait_grant(g);
        check("t6_next", g, 4'b0100);
        tick();
        clr_req(2);
        drain();
        for (int c = 0; c < 10; c++) begin
            check("t6_quiet_ready", bus.req_ready, 0);
            check("t6_quiet_valid", bus.res_valid, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
